des_round_ctrl: RTL and testbench
=================================

# des_round_ctrl

Iterative DES round sequencer. It accepts one initial-permuted 64-bit block and a 56-bit PC-1 key, then runs the 16 Feistel rounds at one round per cycle. Each cycle it presents R and the current rotated C/D key state to a shared external f-function (expansion, PC-2, XOR, S-boxes, P) and returns the swapped R16||L16 pre-output. The final permutation stage consumes that pre-output.

## Interface
- ROUNDS, 16: Feistel rounds per block. Only 16 is supported. Used for counter sizing.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  block and key valid
- in_ready  out  1  controller can accept a block
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- data_i  in  64  post-IP block; [63:32] = L0, [31:0] = R0
- key_i  in  56  post-PC-1 key; [55:28] = C0, [27:0] = D0
- f_r_o  out  32  R operand to the f-function
- f_cd_o  out  56  rotated C/D for the current round, feeds external PC-2
- f_res_i  in  32  combinational f-function result, same cycle
- out_valid  out  1  pre-output valid
- out_ready  in  1  downstream accepts
- data_o  out  64  pre-output; [63:32] = R16, [31:0] = L16
- busy  out  1  high while in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. All state is reset asynchronously by rst_n low.
- Reset values: state = IDLE, round = 0, L/R/CD/mode = 0, in_ready = 1, out_valid = 0, busy = 0, data_o = 0, f_r_o = 0, f_cd_o = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture L, R, CD and mode, set round = 1, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle: f_r_o = R, f_cd_o = rot(CD, amt(round, mode)).
  - Register update: L <= R; R <= L ^ f_res_i; CD <= f_cd_o; round++.
  - After round 16 updates, go to DONE.
- DONE:
  - out_valid = 1, data_o = {R, L}.
  - Hold all values until out_ready. Then go to IDLE.
- C and D rotate independently within 28 bits. Bit [27] is DES bit 1.
  - Left rotate by 1: {x[26:0], x[27]}.
  - Right rotate by 1: {x[0], x[27:1]}.
- Encrypt: left rotate. amt = 1 in rounds 1, 2, 9, 16; otherwise 2 (total 28).
- Decrypt: right rotate. amt = 0 in round 1; 1 in rounds 2, 9, 16; otherwise 2 (total 27).
- f_r_o and f_cd_o are don't-care outside RUN but must be driven, not X. Drive registered R and CD.
- mode and CD are never re-sampled mid-block. Changes on decrypt or key_i during RUN have no effect.
- No accept occurs in the same cycle as out_valid/out_ready completion. A new block is accepted the next cycle, in IDLE.
- rst_n asserted mid-block: the block is discarded and every output returns to its reset value asynchronously.

## Timing
- Accept at edge 0. Rounds 1–16 are computed in cycles 1–16.
- out_valid rises after edge 16, i.e. 17 cycles after accept.
- Minimum issue interval is 18 cycles: accept, 16 rounds, one DONE cycle with out_ready = 1.
- f_res_i lies on a same-cycle combinational path (register → f_cd_o/f_r_o → external f → R register). The external f-function must meet one cycle.
- data_o is registered. No combinational path from out_ready to out_valid.
- in_ready depends only on state. No combinational path from in_valid.

## Configuration
- DES_ROUND_CTRL_ABORT_EN defined:
  - Adds an input port abort_i (1 bit).
  - abort_i high in RUN or DONE forces IDLE on the next edge. out_valid drops and the block is discarded.
  - abort_i in IDLE is ignored. If it coincides with out_ready in DONE, abort wins; no transfer is counted.
- Undefined: no abort_i port. Blocks always run to completion.

## Structure
- Package des_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the ROUNDS constant;
  - a function returning the rotate amount for round and mode;
  - the 28-bit rotl/rotr functions.
- One natural sub-module: des_key_rot. It is combinational and rotates C and D by 0/1/2 in a given direction. The controller instantiates it once.
- The round counter is 5 bits.

## Test plan
- Encrypt known answer: key 133457799BBCDFF1, PT 0123456789ABCDEF, with the bench modelling IP, PC-1, PC-2, f and FP → CT 85E813540F0AB405. out_valid appears exactly 17 cycles after accept.
- Decrypt the same CT with the same key → 0123456789ABCDEF. Check f_cd_o in round 1 equals key_i and in round 16 equals C1D1.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → data_o stable, in_ready = 0. Release → IDLE, in_ready = 1 next cycle.
- Back-to-back: in_valid held high for two blocks with out_ready = 1 → second accept 18 cycles after the first, both results correct.
- Reset at round 8 → all outputs zero immediately. The next block after reset produces the correct CT.
- With DES_ROUND_CTRL_ABORT_EN: abort_i pulsed at round 5 → IDLE next cycle, no out_valid. The following block is correct.

Source files
------------

// File: rtl/des_round_ctrl_pkg.sv
// Shared types and helpers for the iterative DES round controller:
// FSM state encoding, round count and the C/D key-rotation schedule.
package des_pkg;

    localparam int ROUNDS = 16;
    localparam int RND_W  = 5;
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } des_state_e;

    // Bit [27] is DES bit 1, so a DES left shift moves bits toward the MSB.
    function automatic logic [27:0] rotl28(input logic [27:0] x);
        return {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x);
        return {x[0], x[27:1]};
    endfunction

    // Decrypt starts from C16/D16 == C0/D0, so its first round applies no rotation.
    function automatic logic [1:0] rot_amt(input logic [RND_W-1:0] round, input logic mode);
        logic [1:0] amt;
        case (round)
            5'd1:              amt = mode ? 2'd0 : 2'd1;
            5'd2, 5'd9, 5'd16: amt = 2'd1;
            default:           amt = 2'd2;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/des_round_ctrl_key_rot.sv
// Combinational C/D key rotator: rotates both 28-bit halves independently
// by 0, 1 or 2 positions, left for encryption and right for decryption.
module des_key_rot (
    input  logic [55:0] cd_i,
    input  logic [1:0]  amt_i,
    input  logic        dir_right_i,
    output logic [55:0] cd_o
);
    import des_pkg::*;

    logic [27:0] c_s;
    logic [27:0] d_s;

    function automatic logic [27:0] rot_once(input logic [27:0] x, input logic right);
        return right ? rotr28(x) : rotl28(x);
    endfunction

    // Apply the requested number of single-step rotations to each half.
    always_comb begin
        c_s = cd_i[55:28];
        d_s = cd_i[27:0];
        case (amt_i)
            2'd0: begin
                c_s = cd_i[55:28];
                d_s = cd_i[27:0];
            end
            2'd1: begin
                c_s = rot_once(cd_i[55:28], dir_right_i);
                d_s = rot_once(cd_i[27:0], dir_right_i);
            end
            2'd2: begin
                c_s = rot_once(rot_once(cd_i[55:28], dir_right_i), dir_right_i);
                d_s = rot_once(rot_once(cd_i[27:0], dir_right_i), dir_right_i);
            end
            default: begin
                c_s = cd_i[55:28];
                d_s = cd_i[27:0];
            end
        endcase
    end

    assign cd_o = {c_s, d_s};

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: one Feistel round per cycle against an
// external f-function. Optional abort input enabled by DES_ROUND_CTRL_ABORT_EN.
module des_round_ctrl
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [63:0] data_i,
    input  logic [55:0] key_i,
    output logic [31:0] f_r_o,
    output logic [55:0] f_cd_o,
    input  logic [31:0] f_res_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_o,
    output logic        busy
`ifdef DES_ROUND_CTRL_ABORT_EN
    ,
    input  logic        abort_i
`endif
);

    des_state_e       state_q,     state_d;
    logic [RND_W-1:0] round_q,     round_d;
    logic [31:0]      l_q,         l_d;
    logic [31:0]      r_q,         r_d;
    logic [55:0]      cd_q,        cd_d;
    logic             mode_q,      mode_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic [63:0]      data_o_q,    data_o_d;

    logic [1:0]       amt_s;
    logic [55:0]      cd_rot_s;
    logic [31:0]      r_next_s;
    logic             abort_s;

`ifdef DES_ROUND_CTRL_ABORT_EN
    assign abort_s = abort_i && (state_q != IDLE);
`else
    assign abort_s = 1'b0;
`endif

    // Outside RUN the rotator passes the registered CD straight through.
    assign amt_s    = (state_q == RUN) ? rot_amt(round_q, mode_q) : 2'd0;
    assign r_next_s = l_q ^ f_res_i;

    des_key_rot u_key_rot (
        .cd_i        (cd_q),
        .amt_i       (amt_s),
        .dir_right_i (mode_q),
        .cd_o        (cd_rot_s)
    );

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        l_d         = l_q;
        r_d         = r_q;
        cd_d        = cd_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        data_o_d    = data_o_q;
        if (abort_s) begin
            state_d     = IDLE;
            round_d     = 5'd0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d    = RUN;
                        round_d    = 5'd1;
                        l_d        = data_i[63:32];
                        r_d        = data_i[31:0];
                        cd_d       = key_i;
                        mode_d     = decrypt;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end
                end
                RUN: begin
                    l_d     = r_q;
                    r_d     = r_next_s;
                    cd_d    = cd_rot_s;
                    round_d = round_q + 5'd1;
                    if (round_q == LAST_ROUND) begin
                        // Pre-output swaps the halves: {R16, L16}.
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        data_o_d    = {r_next_s, r_q};
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        round_d     = 5'd0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    round_d     = 5'd0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; async reset returns every output to idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_q     <= 5'd0;
            l_q         <= 32'd0;
            r_q         <= 32'd0;
            cd_q        <= 56'd0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            data_o_q    <= 64'd0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            l_q         <= l_d;
            r_q         <= r_d;
            cd_q        <= cd_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            data_o_q    <= data_o_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_o    = data_o_q;
    assign f_r_o     = r_q;
    assign f_cd_o    = cd_rot_s;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl: a full DES reference model plus the external
// f-function; abort scenario included when DES_ROUND_CTRL_ABORT_EN is defined.
module tb_des_round_ctrl;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
                                2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

    typedef struct {
        logic [63:0] res;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        decrypt;
    logic [63:0] data_i;
    logic [55:0] key_i;
    logic [31:0] f_r_o;
    logic [55:0] f_cd_o;
    logic [31:0] f_res_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_o;
    logic        busy;
`ifdef DES_ROUND_CTRL_ABORT_EN
    logic        abort_i;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    logic rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DES reference functions ----------------
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] f_k(input logic [31:0] r, input logic [47:0] k);
        logic [47:0]  e;
        logic [31:0]  s;
        logic [31:0]  p;
        logic [5:0]   six;
        logic [255:0] sb;
        int           idx;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            six = e[47-6*j -: 6];
            idx = 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1]);
            sb  = SB[j];
            s[31-4*j -: 4] = sb[255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    // Whole-cipher model: standard key schedule, decrypt by reversed subkeys.
    function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] key, input logic dec);
        logic [55:0] k;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] sk [16];
        logic [63:0] t;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] tmp;
        k = perm_pc1(key);
        c = k[55:28];
        d = k[27:0];
        for (int i = 0; i < 16; i++) begin
            c = (c << SHIFTS[i]) | (c >> (28 - SHIFTS[i]));
            d = (d << SHIFTS[i]) | (d >> (28 - SHIFTS[i]));
            sk[i] = perm_pc2({c, d});
        end
        t = perm_ip(blk);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r   = l ^ f_k(r, sk[dec ? 15 - i : i]);
            l   = tmp;
        end
        return perm_fp({r, l});
    endfunction

    // External f-function the controller drives each round.
    assign f_res_i = f_k(f_r_o, perm_pc2(f_cd_o));

    des_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decrypt   (decrypt),
        .data_i    (data_i),
        .key_i     (key_i),
        .f_r_o     (f_r_o),
        .f_cd_o    (f_cd_o),
        .f_res_i   (f_res_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .busy      (busy)
`ifdef DES_ROUND_CTRL_ABORT_EN
        ,
        .abort_i   (abort_i)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, in_ready, 64'd1);
        chk({nm, "_out_valid"}, out_valid, 64'd0);
        chk({nm, "_busy"}, busy, 64'd0);
        chk({nm, "_data_o"}, data_o, 64'd0);
        chk({nm, "_f_r_o"}, f_r_o, 64'd0);
        chk({nm, "_f_cd_o"}, f_cd_o, 64'd0);
    endtask

    // Waits for in_ready; returns one tick after the accepting edge (round 1 cycle).
    task automatic wait_accept(output int acc_cyc);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", in_ready, 64'd1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] blk, input logic [63:0] key, input logic dec,
                        input logic push, input logic [63:0] exp_res, input string nm);
        exp_t e;
        int   a;
        data_i   = perm_ip(blk);
        key_i    = perm_pc1(key);
        decrypt  = dec;
        in_valid = 1'b1;
        if (push) begin
            e.res = exp_res;
            e.nm  = nm;
            exp_q.push_back(e);
        end
        wait_accept(a);
        in_valid = 1'b0;
        data_i   = {$urandom, $urandom};
        key_i    = {$urandom, 24'($urandom)};
        decrypt  = ~dec;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: fixed level or random backpressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? 1'($urandom) : rdy_fixed;
        end
    end

    // Monitor: latency, hold stability and scoreboard comparison on each transfer.
    initial begin
        logic        ov_prev = 1'b0;
        logic        xfer_prev = 1'b0;
        logic        xfer;
        logic [63:0] hold = 64'd0;
        int          acc;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_q.delete();
                ov_prev   = 1'b0;
                xfer_prev = 1'b0;
            end else begin
                xfer = out_valid && out_ready;
`ifdef DES_ROUND_CTRL_ABORT_EN
                if (abort_i && busy) acc_q.delete();
                xfer = xfer && !abort_i;
`endif
                if (xfer_prev) chk("idle_after_xfer", {in_ready, out_valid, busy}, 64'b100);
                if (in_valid && in_ready) acc_q.push_back(cyc);
                if (out_valid && !ov_prev) begin
                    if (acc_q.size() == 0) acc = -1000;
                    else acc = acc_q.pop_front();
                    chk("latency", 64'(cyc - acc), 64'd17);
                    hold = data_o;
                end
                if (out_valid) begin
                    chk("hold_data", data_o, hold);
                    chk("hold_in_ready", {in_ready, busy}, 64'b01);
                end
                if (xfer) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(e.nm, perm_fp(data_o), e.res);
                    end
                end
                xfer_prev = xfer;
                ov_prev   = out_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [55:0] k56;
        logic [27:0] c0;
        logic [27:0] d0;
        logic [63:0] blk;
        logic [63:0] key;
        logic        dec;
        exp_t        e;
        int          a1;
        int          a2;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        decrypt  = 1'b0;
        data_i   = 64'd0;
        key_i    = 56'd0;
`ifdef DES_ROUND_CTRL_ABORT_EN
        abort_i  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer encrypt and decrypt, model sanity first.
        chk("model_kat_enc", des_ref(KAT_PT, KAT_KEY, 1'b0), KAT_CT);
        chk("model_kat_dec", des_ref(KAT_CT, KAT_KEY, 1'b1), KAT_PT);
        send(KAT_PT, KAT_KEY, 1'b0, 1'b1, KAT_CT, "kat_enc");
        drain();

        k56 = perm_pc1(KAT_KEY);
        c0  = k56[55:28];
        d0  = k56[27:0];
        send(KAT_CT, KAT_KEY, 1'b1, 1'b1, KAT_PT, "kat_dec");
        chk("dec_round1_cd", f_cd_o, k56);
        repeat (15) @(posedge clk);
        #1;
        chk("dec_round16_cd", f_cd_o, {(c0 << 1) | (c0 >> 27), (d0 << 1) | (d0 >> 27)});
        drain();

        // Backpressure: result held for 10 cycles in DONE.
        rdy_fixed = 1'b0;
        blk = {$urandom, $urandom};
        key = {$urandom, $urandom};
        send(blk, key, 1'b0, 1'b1, des_ref(blk, key, 1'b0), "backpressure");
        repeat (30) begin
            if (!out_valid) @(posedge clk);
        end
        #1;
        chk("bp_out_valid", out_valid, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_in_ready", in_ready, 64'd0);
        rdy_fixed = 1'b1;
        drain();

        // Back-to-back with in_valid held high.
        blk = {$urandom, $urandom};
        key = {$urandom, $urandom};
        data_i   = perm_ip(blk);
        key_i    = perm_pc1(key);
        decrypt  = 1'b0;
        in_valid = 1'b1;
        e.res = des_ref(blk, key, 1'b0);
        e.nm  = "b2b_first";
        exp_q.push_back(e);
        wait_accept(a1);
        blk = {$urandom, $urandom};
        key = {$urandom, $urandom};
        data_i  = perm_ip(blk);
        key_i   = perm_pc1(key);
        decrypt = 1'b1;
        e.res = des_ref(blk, key, 1'b1);
        e.nm  = "b2b_second";
        exp_q.push_back(e);
        wait_accept(a2);
        in_valid = 1'b0;
        chk("b2b_interval", 64'(a2 - a1), 64'd18);
        drain();

        // Reset during round 8 discards the block.
        blk = {$urandom, $urandom};
        key = {$urandom, $urandom};
        send(blk, key, 1'b0, 1'b0, 64'd0, "");
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(KAT_PT, KAT_KEY, 1'b0, 1'b1, KAT_CT, "kat_after_reset");
        drain();

`ifdef DES_ROUND_CTRL_ABORT_EN
        // Abort during round 5.
        blk = {$urandom, $urandom};
        key = {$urandom, $urandom};
        send(blk, key, 1'b1, 1'b0, 64'd0, "");
        repeat (4) @(posedge clk);
        #1;
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        chk("abort_idle", {in_ready, out_valid, busy}, 64'b100);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_output", out_valid, 64'd0);
        blk = {$urandom, $urandom};
        key = {$urandom, $urandom};
        send(blk, key, 1'b0, 1'b1, des_ref(blk, key, 1'b0), "after_abort");
        drain();
`endif

        // Random blocks with random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 14; i++) begin
            blk = {$urandom, $urandom};
            key = {$urandom, $urandom};
            dec = 1'($urandom);
            send(blk, key, dec, 1'b1, des_ref(blk, key, dec), dec ? "rand_dec" : "rand_enc");
        end
        drain();
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
